operand_buffer: RTL and testbench
=================================

# operand_buffer

- Parametrised operand-pair input stage for the multiplier datapath.
- Accepts A/B operand pairs over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Presents the oldest pair to the multiplier core through registered outputs, with a lock input that freezes the output side.
- Replaces the fixed 8-bit single-register input latch. Sits between the operand source and the multiplier core.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥1)
- DEPTH, 4, FIFO capacity in operand pairs (power of two, ≥2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush; empties the FIFO
- locked  in  1  freezes the output side; pops inhibited
- in_valid  in  1  operand pair on a/b is valid
- in_ready  out  1  FIFO can accept a pair; equals !full
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  head pair available; equals !empty && !locked
- out_ready  in  1  consumer takes head pair
- a_out  out  WIDTH  head operand A, registered
- b_out  out  WIDTH  head operand B, registered
- count  out  $clog2(DEPTH)+1  number of stored pairs, registered
- drop_cnt  out  8  present only with OPERAND_BUFFER_DROP_CNT_EN

## Operation
- **Push:** occurs when in_valid && in_ready. The pair is written at the write pointer, and the write pointer increments modulo DEPTH.
- **Pop:** occurs when out_valid && out_ready. The read pointer increments modulo DEPTH.
- **Count:**
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- **full / empty:** full = (count == DEPTH); empty = (count == 0). Derived from registered count, never from pointer compare alone.
- **Full buffer:** in_ready = 0, even if a pop occurs that cycle. No push-through when full.
- **Empty buffer:** out_valid = 0. A pair pushed into an empty FIFO is not poppable in the same cycle.
- **a_out/b_out update:** registered. Each edge they load the entry that will be at the head after that edge's push/pop, provided the FIFO is non-empty after the edge. When the FIFO becomes empty they hold the last head value.
- **locked = 1:**
  - out_valid forced 0; no pop regardless of out_ready
  - a_out/b_out/read pointer held
  - pushes still accepted while not full
- **locked = 0:** out_valid reflects !empty combinationally in the same cycle.
- **clr = 1:**
  - pointers and count go to 0; a_out/b_out go to 0
  - clr has priority over a simultaneous push/pop; that push is discarded and is not counted as a drop
- **rst low (any time, including mid-transfer):** immediately forces pointers = 0, count = 0, a_out = 0, b_out = 0, drop_cnt = 0. Storage array contents are don't-care. After reset: in_ready = 1, out_valid = 0.

## Timing
- **Latency:** push at edge N → out_valid = 1 and a_out/b_out valid after edge N (cycle N+1), if locked = 0.
- **Throughput:** one push and one pop per cycle sustained when neither full nor empty.
- **in_ready:** function of registered count only; no combinational path from out_ready.
- **out_valid:** combinational from registered count and the locked input only.
- **Producer rule:** may hold in_valid high with stable a/b until accepted. The buffer never drops an offered pair except via clr.
- **count:** reflects the state after the most recent edge.

## Configuration
- **OPERAND_BUFFER_DROP_CNT_EN defined:**
  - adds 8-bit output drop_cnt
  - increments on each cycle with in_valid && !in_ready && !clr
  - saturates at 255
  - cleared only by rst (not by clr)
- **Not defined:** drop_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset / fill / drain:** reset, then push pairs (1,2), (3,4), (5,6), (7,7) with out_ready = 0 →
  - count = 4, in_ready = 0
  - draining with out_ready = 1 yields a_out/b_out = 1/2, 3/4, 5/6, 7/7 on consecutive cycles, then out_valid = 0 with a_out/b_out holding 7/7
- **Simultaneous push/pop at count = 2:** count stays 2. Order is preserved across the pointer wrap, checked with 10 pairs (0xA0+i, 0x50+i).
- **Lock:** with 2 entries queued, locked = 1 and out_ready = 1 for 5 cycles →
  - out_valid = 0, a_out/b_out unchanged
  - one further push accepted, count = 3
  - unlock → out_valid = 1 in the same cycle
- **Full backpressure:** push a fifth pair 0xFF/0xFF while full and popping → in_ready = 0, pair not accepted. With the macro defined, drop_cnt = 1, and it saturates at 255 after 300 stalled cycles.
- **Flush vs. reset:**
  - clr asserted together with in_valid at count = 3 → count = 0, a_out = b_out = 0, no drop counted
  - rst asserted mid-drain → all outputs go to reset values before the next edge

Source files
------------

// File: rtl/operand_buffer.sv
// operand_buffer: operand-pair input stage for the multiplier datapath.
//
// Accepts A/B operand pairs over a valid/ready handshake, queues them in a
// DEPTH-entry FIFO and presents the oldest pair on registered outputs.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1)
//   DEPTH  FIFO capacity in operand pairs (power of two, >= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   clr        synchronous flush (pointers, count, a_out/b_out to 0)
//   locked     freezes the output side; no pops while high
//   in_valid   a/b carry a valid pair
//   in_ready   FIFO can accept a pair (!full)
//   a, b       incoming operands
//   out_valid  head pair available (!empty && !locked)
//   out_ready  consumer takes the head pair
//   a_out      head operand A, registered
//   b_out      head operand B, registered
//   count      number of stored pairs, registered
//   drop_cnt   saturating count of refused offers (only with
//              OPERAND_BUFFER_DROP_CNT_EN defined)
//
// Optional feature macro: OPERAND_BUFFER_DROP_CNT_EN
module operand_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     locked,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         a_out,
    output logic [WIDTH-1:0]         b_out,
    output logic [$clog2(DEPTH):0]   count
`ifdef OPERAND_BUFFER_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] b_out_q, b_out_d;

    logic             full, empty, push, pop;
    logic [PW-1:0]    head_idx;
    logic             bypass;

    // Status comes from the registered count only, so neither in_ready nor
    // out_valid has a combinational path from out_ready.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty && !locked;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign a_out = a_out_q;
    assign b_out = b_out_q;
    assign count = count_q;

    // Head slot after this edge's pop.
    assign head_idx = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    // When nothing older survives the pop, the new head is the pair being
    // pushed right now, which is not yet in the array.
    assign bypass = empty || (pop && count_q == CW'(1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        a_out_d  = a_out_q;
        b_out_d  = b_out_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            a_out_d  = '0;
            b_out_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            // Load the post-edge head; hold the last value once empty.
            if (count_d != '0) begin
                if (bypass) begin
                    a_out_d = a;
                    b_out_d = b;
                end else begin
                    a_out_d = mem_a[head_idx];
                    b_out_d = mem_b[head_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_out_q  <= '0;
            b_out_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            a_out_q  <= a_out_d;
            b_out_q  <= b_out_d;
        end
    end

    // Storage needs no reset; contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_a[wr_ptr_q] <= a;
            mem_b[wr_ptr_q] <= b;
        end
    end

`ifdef OPERAND_BUFFER_DROP_CNT_EN
    logic [7:0] drop_q;

    // Cleared by reset only; a flush does not forget past drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (in_valid && !in_ready && !clr && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_operand_buffer.sv
module tb_operand_buffer;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         locked;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [$clog2(D):0] count;
`ifdef OPERAND_BUFFER_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    operand_buffer #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .locked(locked),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_out(a_out),
        .b_out(b_out),
        .count(count)
`ifdef OPERAND_BUFFER_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of pairs plus the visible head and drop count.
    typedef struct packed {
        logic [W-1:0] pa;
        logic [W-1:0] pb;
    } pair_t;

    pair_t        q[$];
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    int           mdrop;

    int n_vec;
    int n_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs();
        chk("count", 32'(count), 32'(q.size()));
        chk("a_out", 32'(a_out), 32'(ma));
        chk("b_out", 32'(b_out), 32'(mb));
`ifdef OPERAND_BUFFER_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
`endif
    endtask

    // One clock cycle: apply inputs, check handshake outputs before the edge,
    // advance the model, check registered outputs after the edge.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic lk, input logic ordy, input logic cl);
        bit er, ev, do_push, do_pop;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        locked    = lk;
        out_ready = ordy;
        clr       = cl;
        #1;
        er = (q.size() < D);
        ev = (q.size() != 0) && !lk;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        do_push = iv && er;
        do_pop  = ev && ordy;
        if (cl) begin
            q.delete();
            ma = '0;
            mb = '0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(pair_t'{pa: ia, pb: ib});
            if (q.size() != 0) begin
                ma = q[0].pa;
                mb = q[0].pb;
            end
        end
        if (iv && !er && !cl && mdrop < 255) mdrop++;
        @(posedge clk);
        #1;
        chk_regs();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        ma        = '0;
        mb        = '0;
        mdrop     = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        locked    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk_regs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Fill with out_ready low, then drain
        step(1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd7, 8'd7, 1'b0, 1'b0, 1'b0);
        chk("full count", 32'(count), 32'd4);
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("drained a_out", 32'(a_out), 32'd7);
        chk("drained b_out", 32'(b_out), 32'd7);

        // Full backpressure: offer 0xFF/0xFF while full and popping
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h30, 8'h31, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'hEE, 8'hEE, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Lock with two entries queued
        step(1'b1, 8'h41, 8'h42, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h43, 8'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h45, 8'h46, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("locked count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // Simultaneous push/pop at count 2, across the pointer wrap
        step(1'b1, 8'hA0, 8'h50, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 8'h51, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < 10; i++) step(1'b1, 8'(8'hA0 + i), 8'(8'h50 + i), 1'b0, 1'b1, 1'b0);
        chk("pushpop count", 32'(count), 32'd2);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // Flush with a simultaneous offer at count 3
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 8'h98, 1'b0, 1'b0, 1'b1);
        chk("flush a_out", 32'(a_out), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0));
        end

        // Reset mid-drain: outputs must reach reset values before the next edge
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        q.delete();
        ma    = '0;
        mb    = '0;
        mdrop = 0;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk_regs();
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
